// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounced active-low buttons -> typed event stream
// press/release/long/repeat per button, round-robin into FWFT FIFO
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   btn_db[N_BTN]       debounced levels, 0 = pressed
//   evt_valid/ready     consumer handshake on FIFO head
//   evt_id, evt_type    head event (00 press 01 rel 10 long 11 rep)
//   evt_overflow        1-cycle pulse per dropped event
//   btn_held[N_BTN]     button FSM is DOWN or LONG
module btn_event_ctrl #(
  parameter int N_BTN         = 4,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int FIFO_DEPTH    = 4,
  localparam int IW = $clog2(N_BTN),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_db,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW-1:0]    evt_id,
  output logic [1:0]       evt_type,
  output logic             evt_overflow,
  output logic [N_BTN-1:0] btn_held
);

  typedef enum logic [1:0] {
    S_UP,
    S_DOWN,
    S_LONG
  } st_t;

  localparam logic [1:0] EV_PRESS = 2'd0;
  localparam logic [1:0] EV_REL   = 2'd1;
  localparam logic [1:0] EV_LONG  = 2'd2;
  localparam logic [1:0] EV_REP   = 2'd3;

  localparam logic [31:0] LONG_TOP = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] REP_TOP  = 32'(REPEAT_CYCLES - 1);

  logic [N_BTN-1:0] btn_prev;
  logic [N_BTN-1:0] pr;
  logic [N_BTN-1:0] rl;
  st_t              st     [N_BTN];
  st_t              st_n   [N_BTN];
  logic [31:0]      cnt    [N_BTN];
  logic [31:0]      cnt_n  [N_BTN];
  logic [N_BTN-1:0] raise;
  logic [1:0]       rty    [N_BTN];
  logic [N_BTN-1:0] slot_occ;
  logic [1:0]       slot_ty [N_BTN];
  logic [N_BTN-1:0] gnt;
  logic [N_BTN-1:0] drop;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic             found;
  int               idx;

  logic [IW+1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_n;
  logic [AW:0]      count;
  logic [AW:0]      cnt_left;
  logic             can_push;
  logic             push;
  logic             pop;
  logic [IW+1:0]    push_data;
  logic [IW+1:0]    head;

  assign pr = btn_prev & ~btn_db;
  assign rl = ~btn_prev & btn_db;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      st_n[i]  = st[i];
      cnt_n[i] = cnt[i];
      raise[i] = 1'b0;
      rty[i]   = EV_PRESS;
      case (st[i])
        S_UP: begin
          if (pr[i]) begin
            st_n[i]  = S_DOWN;
            cnt_n[i] = '0;
            raise[i] = 1'b1;
          end
        end
        S_DOWN: begin
          if (rl[i]) begin
            st_n[i]  = S_UP;
            cnt_n[i] = '0;
            raise[i] = 1'b1;
            rty[i]   = EV_REL;
          end else if (cnt[i] == LONG_TOP) begin
            st_n[i]  = S_LONG;
            cnt_n[i] = '0;
            raise[i] = 1'b1;
            rty[i]   = EV_LONG;
          end else begin
            cnt_n[i] = cnt[i] + 32'd1;
          end
        end
        S_LONG: begin
          if (rl[i]) begin
            st_n[i]  = S_UP;
            cnt_n[i] = '0;
            raise[i] = 1'b1;
            rty[i]   = EV_REL;
          end else if (cnt[i] == REP_TOP) begin
            cnt_n[i] = '0;
            raise[i] = 1'b1;
            rty[i]   = EV_REP;
          end else begin
            cnt_n[i] = cnt[i] + 32'd1;
          end
        end
        default: begin
          st_n[i]  = S_UP;
          cnt_n[i] = '0;
        end
      endcase
    end
  end

  // Round-robin search starting at ptr; pop does not free
  // space for this cycle's push, so only count gates it.
  assign can_push = count < (AW+1)'(FIFO_DEPTH);

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(ptr) + k) % N_BTN;
      if (!found && can_push && slot_occ[idx]) begin
        found = 1'b1;
        gidx  = IW'(idx);
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  // A slot being granted this cycle can take the new event.
  assign drop = raise & slot_occ & ~gnt;

  assign push      = found;
  assign pop       = (count != '0) && evt_ready;
  assign push_data = {gidx, slot_ty[gidx]};
  assign cnt_left  = count - (AW+1)'(pop);
  assign rd_n      = rd_ptr + AW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev     <= '1;
      btn_held     <= '0;
      slot_occ     <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        st[i]      <= S_UP;
        cnt[i]     <= '0;
        slot_ty[i] <= EV_PRESS;
      end
    end else begin
      btn_prev     <= btn_db;
      evt_overflow <= |drop;
      for (int i = 0; i < N_BTN; i++) begin
        st[i]       <= st_n[i];
        cnt[i]      <= cnt_n[i];
        btn_held[i] <= (st_n[i] != S_UP);
        if (raise[i]) begin
          if (!drop[i]) begin
            slot_occ[i] <= 1'b1;
            slot_ty[i]  <= rty[i];
          end
        end else if (gnt[i]) begin
          slot_occ[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else begin
      if (found) begin
        ptr <= (int'(gidx) == N_BTN - 1) ? '0 : gidx + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_n;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      // Head register holds its value while the FIFO is empty.
      if (cnt_left == '0) begin
        if (push) head <= push_data;
      end else begin
        head <= mem[rd_n];
      end
    end
  end

  assign evt_valid = (count != '0);
  assign evt_id    = head[IW+1:2];
  assign evt_type  = head[1:0];

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed checks of btn_event_ctrl
// small LONG/REPEAT params, event log compared to hand values
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn_db = 4'hF;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_overflow;
  logic [3:0] btn_held;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ovf_n = 0;
  int q_id[$];
  int q_ty[$];
  int q_cy[$];
  bit tog = 1'b0;
  int t;
  int o0;

  btn_event_ctrl #(
    .N_BTN(4),
    .LONG_CYCLES(8),
    .REPEAT_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_db(btn_db),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_type(evt_type),
    .evt_overflow(evt_overflow),
    .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        q_id.push_back(int'(evt_id));
        q_ty.push_back(int'(evt_type));
        q_cy.push_back(cyc);
      end
      if (evt_overflow) ovf_n++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int k,
                        input int id, input int ty, input int cy);
    int gi;
    int gt;
    int gc;
    gi = (k < q_id.size()) ? q_id[k] : -1;
    gt = (k < q_ty.size()) ? q_ty[k] : -1;
    gc = (k < q_cy.size()) ? q_cy[k] : -1;
    chk($sformatf("%s_ev%0d_id", tag, k), gi, id);
    chk($sformatf("%s_ev%0d_ty", tag, k), gt, ty);
    if (cy >= 0) chk($sformatf("%s_ev%0d_cy", tag, k), gc, cy);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tog) evt_ready = ~evt_ready;
    end
  endtask

  task automatic clrq();
    q_id.delete();
    q_ty.delete();
    q_cy.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_type", int'(evt_type), 0);
    chk("rst_ovf", int'(evt_overflow), 0);
    chk("rst_held", int'(btn_held), 0);
    rst_n = 1'b1;
    tick(2);

    // single press on button 0, held 3 cycles
    clrq();
    t = cyc;
    btn_db = 4'b1110;
    tick(2);
    chk("t1_held", int'(btn_held), 1);
    tick(1);
    btn_db = 4'hF;
    tick(6);
    chk("t1_n", q_id.size(), 2);
    chk_ev("t1", 0, 0, 0, t + 2);
    chk_ev("t1", 1, 0, 1, t + 5);
    chk("t1_unheld", int'(btn_held), 0);

    // long press with two repeats on button 2
    clrq();
    o0 = ovf_n;
    t = cyc;
    btn_db = 4'b1011;
    tick(5);
    chk("t2_held", int'(btn_held), 4);
    tick(15);
    btn_db = 4'hF;
    tick(6);
    chk("t2_n", q_id.size(), 5);
    chk_ev("t2", 0, 2, 0, t + 2);
    chk_ev("t2", 1, 2, 2, t + 10);
    chk_ev("t2", 2, 2, 3, t + 14);
    chk_ev("t2", 3, 2, 3, t + 18);
    chk_ev("t2", 4, 2, 1, t + 22);
    chk("t2_ovf", ovf_n - o0, 0);

    // all buttons at once, round-robin from ptr 0
    do_reset();
    clrq();
    t = cyc;
    btn_db = 4'h0;
    tick(6);
    btn_db = 4'hF;
    tick(10);
    chk("t3_n", q_id.size(), 8);
    for (int k = 0; k < 4; k++) chk_ev("t3", k, k, 0, t + 2 + k);
    for (int k = 0; k < 4; k++) chk_ev("t3", 4 + k, k, 1, t + 8 + k);

    // stalled consumer: FIFO fills, slots fill, then drops
    do_reset();
    clrq();
    o0 = ovf_n;
    evt_ready = 1'b0;
    btn_db = 4'h0;
    tick(6);
    btn_db = 4'hF;
    tick(3);
    btn_db = 4'b1110;
    tick(2);
    btn_db = 4'hF;
    tick(3);
    chk("t4_stall_n", q_id.size(), 0);
    chk("t4_valid", int'(evt_valid), 1);
    chk("t4_ovf", ovf_n - o0, 2);
    evt_ready = 1'b1;
    tick(15);
    chk("t4_n", q_id.size(), 8);
    for (int k = 0; k < 4; k++) chk_ev("t4", k, k, 0, -1);
    for (int k = 0; k < 4; k++) chk_ev("t4", 4 + k, k, 1, -1);

    // async reset while button 1 is in LONG, 2 events queued
    clrq();
    o0 = ovf_n;
    evt_ready = 1'b0;
    btn_db = 4'b1101;
    tick(12);
    chk("t5_pre_valid", int'(evt_valid), 1);
    chk("t5_pre_held", int'(btn_held), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(evt_valid), 0);
    chk("t5_rst_held", int'(btn_held), 0);
    tick(2);
    rst_n = 1'b1;
    clrq();
    evt_ready = 1'b1;
    t = cyc;
    tick(3);
    btn_db = 4'hF;
    tick(6);
    chk("t5_n", q_id.size(), 2);
    chk_ev("t5", 0, 1, 0, t + 2);
    chk_ev("t5", 1, 1, 1, t + 5);
    chk("t5_ovf", ovf_n - o0, 0);

    // ready toggling every cycle while events stream
    do_reset();
    clrq();
    o0 = ovf_n;
    tog = 1'b1;
    btn_db = 4'h0;
    tick(6);
    btn_db = 4'hF;
    tick(24);
    tog = 1'b0;
    evt_ready = 1'b1;
    tick(2);
    chk("t6_n", q_id.size(), 8);
    for (int k = 0; k < 4; k++) chk_ev("t6", k, k, 0, -1);
    for (int k = 0; k < 4; k++) chk_ev("t6", 4 + k, k, 1, -1);
    chk("t6_ovf", ovf_n - o0, 0);
    chk("t6_idle", int'(evt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
